// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared types and helpers for the video timing controller.
//   - vt_state_e  : frame sequencer states
//   - vt_timing_t : bundle of horizontal/vertical timing parameters
//   - h_total / v_total : full line / frame lengths derived from a timing set
// -----------------------------------------------------------------------------
package video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } vt_state_e;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vt_timing_t;

    // Clocks per line: sync, back porch, active, front porch.
    function automatic int h_total(input vt_timing_t t);
        return int'(t.h_sync) + int'(t.h_bp) + int'(t.h_active) + int'(t.h_fp);
    endfunction

    // Lines per frame: sync, back porch, active, front porch.
    function automatic int v_total(input vt_timing_t t);
        return int'(t.v_sync) + int'(t.v_bp) + int'(t.v_active) + int'(t.v_fp);
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// -----------------------------------------------------------------------------
// video_timing_cnt
//   Horizontal/vertical position counter pair. While en_i is high the
//   horizontal counter runs 0..H_TOTAL-1 and the vertical counter advances
//   on each horizontal wrap, running 0..V_TOTAL-1. While en_i is low both
//   counters are forced to 0 so a new run always begins at (0,0).
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   en_i     in   advance counters (low = hold at 0)
//   h_cnt_o  out  horizontal position
//   v_cnt_o  out  vertical position
//   eof_o    out  high on the last clock of a frame while enabled
// -----------------------------------------------------------------------------
module video_timing_cnt #(
    parameter int H_TOTAL = 340,
    parameter int V_TOTAL = 246,
    parameter int H_W     = $clog2(H_TOTAL),
    parameter int V_W     = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    output logic [H_W-1:0] h_cnt_o,
    output logic [V_W-1:0] v_cnt_o,
    output logic           eof_o
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic           h_last;
    logic           v_last;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + V_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + H_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
    assign eof_o   = en_i & h_last & v_last;

endmodule

// File: rtl/video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// video_timing_ctrl
//   Frame sequencer producing vsync/hsync/de plus active-pixel position for
//   the head of the video datapath. After a start it runs i_frame_num frames
//   (0 = run until stopped). A stop lets the current frame finish first.
//   Every output is registered one clock after the counter/state it decodes.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   i_start       in   start pulse, honoured only when idle
//   i_stop        in   stop request, takes effect at end of current frame
//   i_frame_num   in   frames to run, latched at start (0 = continuous)
//   o_vsync       out  vertical sync (active high)
//   o_hsync       out  horizontal sync (active high)
//   o_de          out  data enable (active high)
//   o_x / o_y     out  active pixel column / row, 0 outside de
//   o_busy        out  sequencer running or finishing a stop
//   o_frame_done  out  one-clock pulse on the last clock of each frame
//   o_frame_cnt   out  frames completed since the last start (saturating)
// -----------------------------------------------------------------------------
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 2,
    parameter int FCNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic [FCNT_W-1:0]           i_frame_num,
    output logic                        o_vsync,
    output logic                        o_hsync,
    output logic                        o_de,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_busy,
    output logic                        o_frame_done,
    output logic [FCNT_W-1:0]           o_frame_cnt
);

    localparam vt_timing_t TIMING = '{
        h_active: 16'(H_ACTIVE),
        h_fp:     16'(H_FP),
        h_sync:   16'(H_SYNC),
        h_bp:     16'(H_BP),
        v_active: 16'(V_ACTIVE),
        v_fp:     16'(V_FP),
        v_sync:   16'(V_SYNC),
        v_bp:     16'(V_BP)
    };

    localparam int H_TOTAL    = h_total(TIMING);
    localparam int V_TOTAL    = v_total(TIMING);
    localparam int H_W        = $clog2(H_TOTAL);
    localparam int V_W        = $clog2(V_TOTAL);
    localparam int X_W        = $clog2(H_ACTIVE);
    localparam int Y_W        = $clog2(V_ACTIVE);
    localparam int H_DE_START = H_SYNC + H_BP;
    localparam int H_DE_END   = H_DE_START + H_ACTIVE;
    localparam int V_DE_START = V_SYNC + V_BP;
    localparam int V_DE_END   = V_DE_START + V_ACTIVE;

    vt_state_e         state_q, state_d;
    logic [FCNT_W-1:0] frame_num_q, frame_num_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FCNT_W-1:0] fcnt_inc;
    logic              running;

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic              eof;

    logic              vsync_q, vsync_d;
    logic              hsync_q, hsync_d;
    logic              de_q, de_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    int                h_int;
    int                v_int;

    assign running = (state_q != IDLE);

    video_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .H_W     (H_W),
        .V_W     (V_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (running),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .eof_o   (eof)
    );

    // Completed-frame count after this frame ends; holds at all-ones.
    assign fcnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + FCNT_W'(1);

    // Sequencer: next state, latched frame number and completed-frame count.
    always_comb begin
        state_d     = state_q;
        frame_num_d = frame_num_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                // A stop arriving with the start is simply not looked at here.
                if (i_start) begin
                    state_d     = RUN;
                    frame_num_d = i_frame_num;
                    frame_cnt_d = '0;
                end
            end
            RUN, STOP_PEND: begin
                if (eof) begin
                    frame_cnt_d = fcnt_inc;
                    // A stop seen on the end-of-frame clock ends the run now.
                    if ((state_q == STOP_PEND) || i_stop ||
                        ((frame_num_q != '0) && (fcnt_inc == frame_num_q))) begin
                        state_d = IDLE;
                    end
                end else if (i_stop) begin
                    state_d = STOP_PEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current counter/state; registered below.
    always_comb begin
        h_int   = int'(h_cnt);
        v_int   = int'(v_cnt);
        hsync_d = running && (h_int < H_SYNC);
        vsync_d = running && (v_int < V_SYNC);
        de_d    = running &&
                  (h_int >= H_DE_START) && (h_int < H_DE_END) &&
                  (v_int >= V_DE_START) && (v_int < V_DE_END);
        x_d     = de_d ? X_W'(h_int - H_DE_START) : '0;
        y_d     = de_d ? Y_W'(v_int - V_DE_START) : '0;
        busy_d  = running;
        done_d  = eof;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_num_q <= '0;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_num_q <= frame_num_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            de_q        <= de_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_vsync      = vsync_q;
    assign o_hsync      = hsync_q;
    assign o_de         = de_q;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_timing_ctrl
//   Two instances: default timing (line/sync/de geometry, reset mid-line) and
//   a tiny 7x5 timing with a 3-bit frame counter (whole-frame sequencing,
//   stop handling, ignored start, saturation).
//   Cycle index idx = number of clocks since the counters entered (0,0);
//   registered outputs for idx are observed at the falling edge after it.
// -----------------------------------------------------------------------------
module tb_video_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // default-timing instance
    logic        def_start, def_stop;
    logic [15:0] def_fnum;
    logic        def_vsync, def_hsync, def_de, def_busy, def_done;
    logic [8:0]  def_x;
    logic [7:0]  def_y;
    logic [15:0] def_cnt;

    // small-timing instance
    logic        sm_start, sm_stop;
    logic [2:0]  sm_fnum;
    logic        sm_vsync, sm_hsync, sm_de, sm_busy, sm_done;
    logic [1:0]  sm_x;
    logic [0:0]  sm_y;
    logic [2:0]  sm_cnt;

    int checks = 0;
    int errors = 0;

    video_timing_ctrl dut_def (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (def_start),
        .i_stop       (def_stop),
        .i_frame_num  (def_fnum),
        .o_vsync      (def_vsync),
        .o_hsync      (def_hsync),
        .o_de         (def_de),
        .o_x          (def_x),
        .o_y          (def_y),
        .o_busy       (def_busy),
        .o_frame_done (def_done),
        .o_frame_cnt  (def_cnt)
    );

    video_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .FCNT_W   (3)
    ) dut_sm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (sm_start),
        .i_stop       (sm_stop),
        .i_frame_num  (sm_fnum),
        .o_vsync      (sm_vsync),
        .o_hsync      (sm_hsync),
        .o_de         (sm_de),
        .o_x          (sm_x),
        .o_y          (sm_y),
        .o_busy       (sm_busy),
        .o_frame_done (sm_done),
        .o_frame_cnt  (sm_cnt)
    );

    // Expected {busy,done,vsync,hsync,de,x[8:0],y[7:0]} for default timing:
    // line 340 clocks, hsync h<4, de h in [12,332); frame 246 lines,
    // vsync v<2, de v in [4,244).
    function automatic logic [21:0] exp_def(input int idx);
        int h;
        int v;
        logic de;
        logic [8:0] x;
        logic [7:0] y;
        h  = idx % 340;
        v  = (idx / 340) % 246;
        de = (h >= 12) && (h < 332) && (v >= 4) && (v < 244);
        x  = de ? 9'(h - 12) : 9'd0;
        y  = de ? 8'(v - 4) : 8'd0;
        return {1'b1, (h == 339) && (v == 245), v < 2, h < 4, de, x, y};
    endfunction

    // Expected {busy,done,vsync,hsync,de,x[1:0],y[0]} for the small timing:
    // line 7 clocks, hsync h<1, de h in [2,6); frame 5 lines, vsync v<1,
    // de v in [2,4).
    function automatic logic [7:0] exp_sm(input int idx);
        int h;
        int v;
        logic de;
        logic [1:0] x;
        logic [0:0] y;
        h  = idx % 7;
        v  = (idx / 7) % 5;
        de = (h >= 2) && (h < 6) && (v >= 2) && (v < 4);
        x  = de ? 2'(h - 2) : 2'd0;
        y  = de ? 1'(v - 2) : 1'd0;
        return {1'b1, (h == 6) && (v == 4), v < 1, h < 1, de, x, y};
    endfunction

    // Stimulus only: pulse start on the small instance for one clock.
    task automatic sm_kick(input logic [2:0] num, input logic with_stop);
        sm_fnum  = num;
        sm_start = 1'b1;
        sm_stop  = with_stop;
        @(negedge clk);
        sm_start = 1'b0;
        sm_stop  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        def_start = 1'b0; def_stop = 1'b0; def_fnum = '0;
        sm_start  = 1'b0; sm_stop  = 1'b0; sm_fnum  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({def_vsync, def_hsync, def_de, def_x, def_y, def_busy, def_done, def_cnt} !== 41'd0) begin
            errors++;
            $display("FAIL reset_def: got %h expected 0",
                     {def_vsync, def_hsync, def_de, def_x, def_y, def_busy, def_done, def_cnt});
        end
        checks++;
        if ({sm_vsync, sm_hsync, sm_de, sm_x, sm_y, sm_busy, sm_done, sm_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_sm: got %h expected 0",
                     {sm_vsync, sm_hsync, sm_de, sm_x, sm_y, sm_busy, sm_done, sm_cnt});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({def_vsync, def_hsync, def_de, def_busy, def_done, sm_vsync, sm_hsync, sm_de, sm_busy, sm_done} !== 10'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0",
                     {def_vsync, def_hsync, def_de, def_busy, def_done, sm_vsync, sm_hsync, sm_de, sm_busy, sm_done});
        end
        $display("test_reset done");
    endtask

    // Default timing: first 7 lines plus 100 clocks of line 7, per clock.
    task automatic test_default_timing;
        int first_de;
        int n_vs;
        int n_hs;
        int n_de;
        logic [21:0] expv;
        first_de = -1; n_vs = 0; n_hs = 0; n_de = 0;
        def_fnum  = 16'd1;
        def_start = 1'b1;
        @(negedge clk);
        def_start = 1'b0;
        for (int idx = 0; idx < 2480; idx++) begin
            @(negedge clk);
            expv = exp_def(idx);
            checks++;
            if ({def_busy, def_done, def_vsync, def_hsync, def_de, def_x, def_y} !== expv) begin
                errors++;
                $display("FAIL def_timing idx=%0d: got %h expected %h", idx,
                         {def_busy, def_done, def_vsync, def_hsync, def_de, def_x, def_y}, expv);
            end
            if (def_de && first_de < 0) first_de = idx;
            if (def_vsync) n_vs++;
            if (def_hsync) n_hs++;
            if (def_de) n_de++;
        end
        checks++;
        if (first_de !== 1372) begin
            errors++;
            $display("FAIL first_de: got idx %0d expected 1372", first_de);
        end
        checks++;
        if (n_vs !== 680) begin
            errors++;
            $display("FAIL vsync_len: got %0d expected 680", n_vs);
        end
        checks++;
        if (n_hs !== 32) begin
            errors++;
            $display("FAIL hsync_count: got %0d expected 32", n_hs);
        end
        checks++;
        if (n_de !== 1048) begin
            errors++;
            $display("FAIL de_count: got %0d expected 1048", n_de);
        end
        $display("test_default_timing done: first_de=%0d vsync=%0d hsync=%0d de=%0d",
                 first_de, n_vs, n_hs, n_de);
    endtask

    // Counters now sit at line 7, clock 100 (active). Pulse reset one clock.
    task automatic test_reset_midline;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({def_vsync, def_hsync, def_de, def_x, def_y, def_busy, def_done, def_cnt} !== 41'd0) begin
            errors++;
            $display("FAIL midline_reset: got %h expected 0",
                     {def_vsync, def_hsync, def_de, def_x, def_y, def_busy, def_done, def_cnt});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({def_vsync, def_hsync, def_de, def_busy, def_done} !== 5'd0) begin
                errors++;
                $display("FAIL midline_idle cyc=%0d: got %b expected 00000", i,
                         {def_vsync, def_hsync, def_de, def_busy, def_done});
            end
        end
        // Restart must begin at (0,0): both syncs high on the first clock.
        def_fnum  = 16'd1;
        def_start = 1'b1;
        @(negedge clk);
        def_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({def_busy, def_vsync, def_hsync, def_de, def_cnt} !== {4'b1110, 16'd0}) begin
            errors++;
            $display("FAIL restart_origin: got %h expected %h",
                     {def_busy, def_vsync, def_hsync, def_de, def_cnt}, {4'b1110, 16'd0});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset_midline done");
    endtask

    task automatic test_two_frames;
        int n_done;
        int d1;
        int d2;
        int n_de;
        logic [1:0] y_seen;
        logic [7:0] expv;
        n_done = 0; d1 = -1; d2 = -1; n_de = 0; y_seen = 2'b00;
        sm_kick(3'd2, 1'b0);
        for (int idx = 0; idx < 70; idx++) begin
            @(negedge clk);
            expv = exp_sm(idx);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y} !== expv) begin
                errors++;
                $display("FAIL two_frames idx=%0d: got %b expected %b", idx,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y}, expv);
            end
            if (sm_de) begin
                n_de++;
                y_seen[sm_y] = 1'b1;
            end
            if (sm_done) begin
                n_done++;
                if (d1 < 0) d1 = idx; else d2 = idx;
                checks++;
                if (sm_cnt !== 3'(n_done)) begin
                    errors++;
                    $display("FAIL two_frames_cnt idx=%0d: got %0d expected %0d", idx, sm_cnt, n_done);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt} !== {5'd0, 3'd2}) begin
            errors++;
            $display("FAIL two_frames_end: got %b expected %b",
                     {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt}, {5'd0, 3'd2});
        end
        checks++;
        if (d2 - d1 !== 35) begin
            errors++;
            $display("FAIL done_spacing: got %0d expected 35", d2 - d1);
        end
        checks++;
        if (n_de !== 16 || y_seen !== 2'b11) begin
            errors++;
            $display("FAIL de_cover: got de=%0d y_seen=%b expected de=16 y_seen=11", n_de, y_seen);
        end
        $display("test_two_frames done: dones at %0d,%0d de=%0d", d1, d2, n_de);
    endtask

    // Continuous run, stop requested mid frame 2: frame 2 still completes.
    task automatic test_stop_continuous;
        logic [7:0] expv;
        sm_kick(3'd0, 1'b0);
        for (int idx = 0; idx < 70; idx++) begin
            @(negedge clk);
            expv = exp_sm(idx);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y} !== expv) begin
                errors++;
                $display("FAIL stop_cont idx=%0d: got %b expected %b", idx,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y}, expv);
            end
            sm_stop = (idx == 44);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt} !== {5'd0, 3'd2}) begin
                errors++;
                $display("FAIL stop_cont_idle cyc=%0d: got %b expected %b", i,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt}, {5'd0, 3'd2});
            end
        end
        $display("test_stop_continuous done: frame_cnt=%0d", sm_cnt);
    endtask

    // Start with 3 frames, then a second start (with a different count)
    // arrives mid-run and must change nothing.
    task automatic test_start_ignored;
        logic [7:0] expv;
        sm_kick(3'd3, 1'b0);
        checks++;
        if (sm_cnt !== 3'd0) begin
            errors++;
            $display("FAIL cnt_clear_on_start: got %0d expected 0", sm_cnt);
        end
        for (int idx = 0; idx < 105; idx++) begin
            @(negedge clk);
            expv = exp_sm(idx);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y} !== expv) begin
                errors++;
                $display("FAIL start_ignored idx=%0d: got %b expected %b", idx,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y}, expv);
            end
            sm_start = (idx == 40);
            sm_fnum  = (idx == 40) ? 3'd1 : 3'd3;
        end
        @(negedge clk);
        checks++;
        if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt} !== {5'd0, 3'd3}) begin
            errors++;
            $display("FAIL start_ignored_end: got %b expected %b",
                     {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt}, {5'd0, 3'd3});
        end
        $display("test_start_ignored done: frame_cnt=%0d", sm_cnt);
    endtask

    // Start and stop together while idle: start wins, full 2-frame run.
    task automatic test_start_stop_together;
        logic [7:0] expv;
        sm_kick(3'd2, 1'b1);
        for (int idx = 0; idx < 70; idx++) begin
            @(negedge clk);
            expv = exp_sm(idx);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y} !== expv) begin
                errors++;
                $display("FAIL start_stop idx=%0d: got %b expected %b", idx,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y}, expv);
            end
        end
        @(negedge clk);
        checks++;
        if ({sm_busy, sm_done, sm_cnt} !== {2'd0, 3'd2}) begin
            errors++;
            $display("FAIL start_stop_end: got %b expected %b",
                     {sm_busy, sm_done, sm_cnt}, {2'd0, 3'd2});
        end
        $display("test_start_stop_together done");
    endtask

    // Continuous run of 9 frames with a 3-bit count (holds at 7); the stop
    // lands exactly on the last clock of frame 9 and ends the run there.
    task automatic test_saturation;
        logic [7:0] expv;
        int k;
        sm_kick(3'd0, 1'b0);
        for (int idx = 0; idx < 315; idx++) begin
            @(negedge clk);
            expv = exp_sm(idx);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y} !== expv) begin
                errors++;
                $display("FAIL saturation idx=%0d: got %b expected %b", idx,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_x, sm_y}, expv);
            end
            if (sm_done) begin
                k = idx / 35 + 1;
                if (k > 7) k = 7;
                checks++;
                if (sm_cnt !== 3'(k)) begin
                    errors++;
                    $display("FAIL sat_cnt idx=%0d: got %0d expected %0d", idx, sm_cnt, k);
                end
            end
            sm_stop = (idx == 313);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt} !== {5'd0, 3'd7}) begin
                errors++;
                $display("FAIL sat_stop_eof cyc=%0d: got %b expected %b", i,
                         {sm_busy, sm_done, sm_vsync, sm_hsync, sm_de, sm_cnt}, {5'd0, 3'd7});
            end
        end
        $display("test_saturation done: frame_cnt=%0d", sm_cnt);
    endtask

    initial begin
        test_reset();
        test_default_timing();
        test_reset_midline();
        test_two_frames();
        test_stop_continuous();
        test_start_ignored();
        test_start_stop_together();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Frame sequencer that generates the vsync/hsync/de timing stream driving the PPM file-read model and downstream image pipeline.
- Runs a programmable number of frames, or runs continuously, after a start command.
- Provides frame/line/pixel position, busy and frame-done status so benches can sequence multi-frame reads and compare outputs.
- Sits at the head of the video datapath.

Parameters:
- H_ACTIVE, 320, active pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, hsync pulse width (clocks)
- H_BP, 8, horizontal back porch (clocks)
- V_ACTIVE, 240, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- FCNT_W, 16, width of frame count/number fields

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- i_start  in  1  start pulse; accepted only in IDLE
- i_stop  in  1  stop request; current frame completes, then IDLE
- i_frame_num  in  FCNT_W  frames to run, sampled at start; 0 = continuous
- o_vsync  out  1  active-high vertical sync
- o_hsync  out  1  active-high horizontal sync
- o_de  out  1  active-high data enable
- o_x  out  $clog2(H_ACTIVE)  active pixel column, valid when o_de
- o_y  out  $clog2(V_ACTIVE)  active line row, valid when o_de
- o_busy  out  1  high in RUN or STOP_PEND
- o_frame_done  out  1  one-clock pulse at the last clock of each frame
- o_frame_cnt  out  FCNT_W  frames completed since the last start

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-frame aborts immediately; no partial-frame completion.
- Totals:
  - H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP (default 340).
  - V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP (default 246).
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Decode from counters:
  - hsync = h_cnt < H_SYNC.
  - vsync = v_cnt < V_SYNC.
  - de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - o_x = h_cnt - (H_SYNC+H_BP); o_y = v_cnt - (V_SYNC+V_BP); both forced 0 when de = 0.
- All outputs are registered: exactly 1 clock latency from the counter state.
- State machine:
  - IDLE: counters held at 0, syncs/de low. On i_start: latch i_frame_num, clear o_frame_cnt, go to RUN, counters start at (0,0) the next clock.
  - RUN: counters free-run. At h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 (end of frame): pulse o_frame_done and increment o_frame_cnt. If the latched number is nonzero and o_frame_cnt+1 equals it, go to IDLE; otherwise wrap to (0,0) and continue. i_stop in RUN goes to STOP_PEND.
  - STOP_PEND: same as RUN; at end of frame pulses done and goes to IDLE.
  - i_stop on the exact end-of-frame clock goes directly to IDLE.
- Simultaneous and ignored inputs:
  - i_start while busy is ignored.
  - i_start and i_stop together in IDLE: start wins and the stop is discarded.
- o_frame_cnt saturates at all-ones; it never wraps.
- vsync rises only at frame start, so the downstream file-read model sees one falling edge (open) and one rising edge (close) per frame.

Decomposition:
- Package video_timing_pkg holds:
  - the state enum (IDLE, RUN, STOP_PEND);
  - a timing-parameter struct;
  - H_TOTAL/V_TOTAL helper functions.
- Sub-module video_timing_cnt: H/V counter pair with wrap and end-of-frame flag. The FSM and output decode stay in the top.

Test Plan:
- Reset then i_start with i_frame_num=1 (defaults) -> first o_de high exactly 2+12 clocks after the (4 lines + the line's 12 clocks) offset, i.e. at h_cnt 12 / v_cnt 4; 76800 de clocks; one o_frame_done after 83640 clocks; o_busy falls; o_frame_cnt=1.
- Per-line check -> hsync high 4 clocks every 340; de high 320 contiguous clocks; o_x runs 0..319; vsync high for 680 clocks per frame.
- i_frame_num=0 run, i_stop asserted mid-frame 2 -> frame 2 completes, o_frame_cnt=2, then IDLE with all syncs low.
- i_start pulsed during RUN with i_frame_num=3 -> no restart, counters undisturbed, run ends after 3 frames.
- rst_n low for 1 clock mid-active-line -> next clock all outputs 0, state IDLE, no o_frame_done pulse.
- Reduced parameters (H_ACTIVE=4, V_ACTIVE=2, all porches/syncs 1) with i_frame_num=2 -> H_TOTAL=7, V_TOTAL=5, two done pulses 35 clocks apart, o_y covers 0..1.
